// File: rtl/ftdi_rx_cmd_parser.sv
// rtl/ftdi_rx_cmd_parser.sv - FT2232H receive byte stream to 9-byte register-write command decoder
module ftdi_rx_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             CLK_FTDI,
    input  logic             RST_N,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic             cmd_valid,
    output logic [7:0]       cmd_addr,
    output logic [31:0]      cmd_data,
    output logic             err_chk,
    output logic             err_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_HDR1,
        S_HDR2,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       idx;
    logic [7:0]       sum;
    logic [7:0]       addr_sh;
    logic [31:0]      data_sh;
    logic [GAP_W-1:0] gap;
    logic             timeout_hit;
    logic             chk_ok;
    logic             chk_bad;

    always_comb begin
        state_nx    = state;
        timeout_hit = (state != S_HUNT) && !rx_valid && (gap == GAP_W'(TIMEOUT_CYCLES));
        chk_ok      = rx_valid && (state == S_CHK) && (rx_byte == sum);
        chk_bad     = rx_valid && (state == S_CHK) && (rx_byte != sum);
        if (timeout_hit) begin
            state_nx = S_HUNT;
        end else if (rx_valid) begin
            case (state)
                S_HUNT: state_nx = (rx_byte == 8'hAE) ? S_HDR1 : S_HUNT;
                S_HDR1: begin
                    if (rx_byte == 8'hAD)      state_nx = S_HDR2;
                    else if (rx_byte == 8'hAE) state_nx = S_HDR1;
                    else                       state_nx = S_HUNT;
                end
                S_HDR2: begin
                    if (rx_byte == 8'hAC)      state_nx = S_ADDR;
                    else if (rx_byte == 8'hAE) state_nx = S_HDR1;
                    else                       state_nx = S_HUNT;
                end
                S_ADDR: state_nx = S_DATA;
                S_DATA: state_nx = (idx == 2'd3) ? S_CHK : S_DATA;
                S_CHK:  state_nx = S_HUNT;
                default: state_nx = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK_FTDI or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_HUNT;
            idx     <= 2'd0;
            sum     <= 8'h00;
            addr_sh <= 8'h00;
            data_sh <= 32'h0;
            gap     <= '0;
        end else begin
            state <= state_nx;
            // Gap counter only runs while a frame is open and the line is idle.
            if (rx_valid || state == S_HUNT) begin
                gap <= '0;
            end else if (gap != GAP_W'(TIMEOUT_CYCLES)) begin
                gap <= gap + GAP_W'(1);
            end
            if (rx_valid && state == S_ADDR) begin
                addr_sh <= rx_byte;
                sum     <= rx_byte;
                idx     <= 2'd0;
            end else if (rx_valid && state == S_DATA) begin
                data_sh <= {data_sh[23:0], rx_byte};
                sum     <= sum + rx_byte;
                idx     <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK_FTDI or negedge RST_N) begin
        if (!RST_N) begin
            cmd_valid   <= 1'b0;
            cmd_addr    <= 8'h00;
            cmd_data    <= 32'h0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            cmd_valid   <= chk_ok;
            err_chk     <= chk_bad;
            err_timeout <= timeout_hit;
            busy        <= (state_nx != S_HUNT);
            if (chk_ok) begin
                cmd_addr <= addr_sh;
                cmd_data <= data_sh;
                good_cnt <= good_cnt + CNT_W'(1);
            end
            // chk_bad needs rx_valid and timeout_hit needs !rx_valid, so they are exclusive.
            if (chk_bad || timeout_hit) begin
                bad_cnt <= bad_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/ftdi_rx_cmd_parser.md
# ftdi_rx_cmd_parser

Consumes the byte stream read from the FT2232H receive FIFO (host → FPGA) and decodes fixed-length command frames into address/data register writes. It sits directly downstream of the FTDI FIFO read path: every byte sampled while RD# is low arrives here as `rx_byte` with a one-cycle `rx_valid` strobe. Valid frames produce a one-cycle `cmd_valid` pulse. Malformed or stalled frames are dropped and counted.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum idle gap, in `CLK_FTDI` cycles, between bytes inside a frame before the frame is aborted.
- `CNT_W`, default 16: width of the good and bad frame counters.

Ports:
- `CLK_FTDI` in 1: single clock, 60 MHz from the FT2232H. The block has one clock; reset is asynchronous and active-low.
- `RST_N` in 1: asynchronous, active-low reset.
- `rx_byte` in 8: received byte; valid only when `rx_valid` is 1.
- `rx_valid` in 1: one-cycle strobe per received byte; may be high on consecutive cycles.
- `cmd_valid` out 1: one-cycle pulse when a frame passes the checksum.
- `cmd_addr` out 8: decoded address; held until the next `cmd_valid`.
- `cmd_data` out 32: decoded data, big-endian; held until the next `cmd_valid`.
- `err_chk` out 1: one-cycle pulse on checksum mismatch.
- `err_timeout` out 1: one-cycle pulse on an inter-byte timeout.
- `busy` out 1: high while a frame is in progress (state is not HUNT).
- `good_cnt` out CNT_W: count of accepted frames; wraps.
- `bad_cnt` out CNT_W: count of checksum errors plus timeouts; wraps.

## Operation
- Frame format, 9 bytes: `AE AD AC` header, then ADDR, then D3 D2 D1 D0 (MSB first), then CHK.
- CHK is the 8-bit sum, mod 256, of ADDR, D3, D2, D1 and D0. The header bytes are excluded.
- States: HUNT, HDR1, HDR2, ADDR, DATA, CHK. A state advances only on a cycle where `rx_valid` is 1.
- HUNT: byte `AE` → HDR1; any other byte stays in HUNT.
- HDR1: `AD` → HDR2; `AE` stays in HDR1 (resync); any other byte → HUNT.
- HDR2: `AC` → ADDR; `AE` → HDR1; any other byte → HUNT.
- ADDR: latch the byte into the address shadow, start the running sum, go to DATA.
- DATA: shift the byte into the 32-bit data shadow and add it to the sum. After the 4th data byte (2-bit byte index == 3) go to CHK.
- CHK: if the byte equals the sum:
  - copy the shadows to `cmd_addr`/`cmd_data`;
  - pulse `cmd_valid`;
  - increment `good_cnt`.
- CHK: if the byte does not equal the sum:
  - pulse `err_chk`;
  - increment `bad_cnt`;
  - leave `cmd_addr`/`cmd_data` unchanged.
- CHK always returns to HUNT.
- Timeout:
  - The gap counter clears on every `rx_valid` and in HUNT. Otherwise it increments, saturating at TIMEOUT_CYCLES.
  - The frame aborts when the counter equals TIMEOUT_CYCLES, `rx_valid` is 0, and the state is not HUNT. On abort: pulse `err_timeout`, increment `bad_cnt`, go to HUNT.
- Simultaneous events:
  - `rx_valid` in the cycle the gap counter reaches TIMEOUT_CYCLES: the byte is processed and no timeout occurs.
  - `err_chk` and `err_timeout` never fire in the same cycle.
  - `bad_cnt` increments by exactly 1 per error event.
- Counters wrap from all-ones to 0.

## Timing
- Reset values:
  - state HUNT;
  - `cmd_valid`, `err_chk`, `err_timeout`, `busy` = 0;
  - `cmd_addr` = 0x00, `cmd_data` = 0x00000000;
  - `good_cnt` = `bad_cnt` = 0;
  - sum, shadows and gap counter cleared.
- Reset asserted mid-frame discards the partial frame and produces no error pulse.
- All outputs are registered.
- `cmd_valid` and `err_chk` rise on the clock edge after the cycle in which the CHK byte is sampled; `cmd_addr`/`cmd_data` update on that same edge.
- `good_cnt`/`bad_cnt` update on the same edge as their pulse.
- `err_timeout` rises one edge after the abort condition is true.
- `busy` is a registered decode of the state; it rises on the edge after `AE` is sampled in HUNT.
- Throughput: `rx_valid` on every cycle is fully supported. Back-to-back frames yield `cmd_valid` pulses 9 cycles apart.
- There is no backpressure. The consumer must accept `cmd_valid` unconditionally.

## Test plan
- Good frame: `AE AD AC 05 12 34 56 78 19`, one byte per cycle → a single `cmd_valid` pulse one cycle after the `19` byte; `cmd_addr`=0x05, `cmd_data`=0x12345678, `good_cnt`=1, `bad_cnt`=0.
- Bad checksum: the same frame with CHK=`18` → `err_chk` pulse, `bad_cnt`=1, no `cmd_valid`; `cmd_addr`/`cmd_data` keep their previous values.
- Header resync: `00 AE AE AD AC 01 00 00 00 02 03` → `cmd_valid` with `cmd_addr`=0x01, `cmd_data`=0x00000002. Also send `AE AD AE AD AC ...`; that frame must be accepted.
- Timeout: `AE AD` then 300 idle cycles → `err_timeout` pulses once, exactly TIMEOUT_CYCLES+1 cycles after `AD` (default TIMEOUT_CYCLES=255); `busy` falls and `bad_cnt`=1; a following good frame is accepted. Boundary check: a byte arriving exactly at gap count 255 continues the frame with no error.
- Back-to-back: two good frames with `rx_valid` continuous for 18 cycles → two `cmd_valid` pulses 9 cycles apart; `good_cnt`=2.
- Reset mid-frame: assert `RST_N` low after `AE AD AC 05 12` → all outputs return to their reset values with no error pulse; a subsequent good frame decodes correctly.
